// File: rtl/fifo_stream_reader.sv
// Purpose: drains a clk_b-domain FIFO into a valid/ready stream through a 2-entry output buffer.
// Latency: ren_b -> m_valid is 2 cycles; one word per cycle sustained while FIFO non-empty and m_ready=1.
// Backpressure: ren_b gated so buffered + inflight words never exceed 2; m_ready=0 stops reads within one cycle.
// Optional: define FIFO_RD_CNT_EN to add the 16-bit rd_count (words delivered) output and its counter.
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 16
) (
    input  logic                  clk_b,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  empty,
    input  logic [FIFO_WIDTH-1:0] dout_b,
    output logic                  ren_b,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [15:0]           rd_count
`endif
);

    logic [FIFO_WIDTH-1:0] buf_q [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  inflight;
    logic [1:0]            occ;
    logic                  pop;
    logic [2:0]            committed;

    // Words owed to the buffer after this edge; a read is only issued if a slot is guaranteed.
    always_comb begin
        pop       = m_valid & m_ready;
        committed = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
        ren_b     = ~rst & en & ~empty & (committed < 3'd2);
    end

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_q[rd_ptr];

    // Occupancy, pointers and the inflight flag; capture and pop may happen on the same edge.
    always_ff @(posedge clk_b) begin
        if (rst) begin
            occ      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            inflight <= 1'b0;
        end else begin
            occ      <= committed[1:0];
            inflight <= ren_b;
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Data storage: FIFO read data lands in the write slot one cycle after the strobe.
    always_ff @(posedge clk_b) begin
        if (!rst && inflight) begin
            buf_q[wr_ptr] <= dout_b;
        end
    end

`ifdef FIFO_RD_CNT_EN
    // Delivered-word counter, wraps naturally at 16 bits.
    always_ff @(posedge clk_b) begin
        if (rst) begin
            rd_count <= 16'd0;
        end else if (pop) begin
            rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a FIFO model whose word i holds i+1,
// an in-order scoreboard on every pop, and hand-computed checks at each step.
module tb_fifo_stream_reader;

    logic        clk_b = 1'b0;
    logic        rst;
    logic        en;
    logic        empty;
    logic [15:0] dout_b = 16'd0;
    logic        ren_b;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
`ifdef FIFO_RD_CNT_EN
    logic [15:0] rd_count;
`endif

    int          total = 0;
    int          bad = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          exp_idx = 0;
    int          pops = 0;
    logic        force_empty = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'd0;
    logic [15:0] exp_word;

    always #5 clk_b = ~clk_b;

    fifo_stream_reader #(.FIFO_WIDTH(16)) dut (
        .clk_b    (clk_b),
        .rst      (rst),
        .en       (en),
        .empty    (empty),
        .dout_b   (dout_b),
        .ren_b    (ren_b),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_count (rd_count)
`endif
    );

    // FIFO model: word at index i carries value i+1, read data valid the cycle after ren_b.
    assign empty = force_empty | (rd_cnt == wr_cnt);

    always @(posedge clk_b) begin
        if (ren_b) begin
            dout_b <= 16'(rd_cnt + 1);
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard and hold checks on the falling edge, return 1 ns after the rising edge.
    task automatic tick();
        @(negedge clk_b);
        chk("no_empty_read", 32'(ren_b & empty), 32'd0);
        if (prev_stall) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid && m_ready && !rst) begin
            exp_word = 16'(exp_idx + 1);
            chk("order", 32'(m_data), 32'(exp_word));
            exp_idx++;
            pops++;
        end
        prev_stall = m_valid & ~m_ready & ~rst;
        prev_data  = m_data;
        @(posedge clk_b);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (exp_idx < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(exp_idx), 32'(target));
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        m_ready = 1'b1;
        wr_cnt  = 100;
        @(posedge clk_b);
        #1;
        tick();
        tick();

        // Reset holds reads off even with data available.
        chk("rst_ren", 32'(ren_b), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
`ifdef FIFO_RD_CNT_EN
        chk("rst_count", 32'(rd_count), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("rel_ren", 32'(ren_b), 32'd1);
        chk("rel_valid", 32'(m_valid), 32'd0);
        tick();
        chk("lat1_valid", 32'(m_valid), 32'd0);
        chk("lat1_ren", 32'(ren_b), 32'd1);
        tick();
        chk("lat2_valid", 32'(m_valid), 32'd1);
        chk("lat2_data", 32'(m_data), 32'h0001);

        // Streaming: word k pops on the k-th tick from here, so 100 ticks deliver all 100.
        for (int i = 0; i < 100; i++) begin
            tick();
        end
        chk("stream_count", 32'(exp_idx), 32'd100);
        chk("stream_pops", 32'(pops), 32'd100);
        chk("stream_reads", 32'(rd_cnt), 32'd100);
        chk("stream_ren_end", 32'(ren_b), 32'd0);
        chk("stream_valid_end", 32'(m_valid), 32'd0);
`ifdef FIFO_RD_CNT_EN
        chk("stream_rd_count", 32'(rd_count), 32'd100);
`endif

        // Backpressure mid-stream for 10 cycles.
        wr_cnt = 140;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("bp_pre_idx", 32'(exp_idx), 32'd103);
        m_ready = 1'b0;
        #1;
        chk("bp_ren_drop", 32'(ren_b), 32'd0);
        tick();
        chk("bp_valid", 32'(m_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_ren_held", 32'(ren_b), 32'd0);
            chk("bp_data", 32'(m_data), 32'h0068);
        end
        m_ready = 1'b1;
        #1;
        chk("bp_resume_ren", 32'(ren_b), 32'd1);
        wait_drain("bp_drain", 140, 100);

        // FIFO reports empty for 20 cycles: no reads, buffer drains.
        wr_cnt = 160;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        force_empty = 1'b1;
        #1;
        chk("emp_ren_now", 32'(ren_b), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("emp_ren", 32'(ren_b), 32'd0);
        end
        chk("emp_valid", 32'(m_valid), 32'd0);
        chk("emp_nolost", 32'(exp_idx), 32'(rd_cnt));
        force_empty = 1'b0;
        wait_drain("emp_drain", 160, 100);

        // Enable drops with a word inflight: it is still captured and delivered.
        wr_cnt = 180;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        en = 1'b0;
        #1;
        chk("en_ren", 32'(ren_b), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        chk("en_stop_idx", 32'(exp_idx), 32'd164);
        chk("en_stop_reads", 32'(rd_cnt), 32'd164);
        chk("en_valid", 32'(m_valid), 32'd0);
        en = 1'b1;
        wait_drain("en_drain", 180, 100);

        // Reset with a full buffer: buffered words 183,184 are discarded.
        wr_cnt = 200;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        m_ready = 1'b0;
        tick();
        chk("mr_full_valid", 32'(m_valid), 32'd1);
        chk("mr_full_ren", 32'(ren_b), 32'd0);
        rst = 1'b1;
        tick();
        chk("mr_valid", 32'(m_valid), 32'd0);
        chk("mr_ren", 32'(ren_b), 32'd0);
`ifdef FIFO_RD_CNT_EN
        chk("mr_count", 32'(rd_count), 32'd0);
`endif
        rst     = 1'b0;
        pops    = 0;
        exp_idx = rd_cnt;
        chk("mr_reads", 32'(rd_cnt), 32'd184);
        m_ready = 1'b1;
        tick();
        tick();
        chk("mr_fresh_valid", 32'(m_valid), 32'd1);
        chk("mr_fresh_data", 32'(m_data), 32'h00b9);
        wait_drain("mr_drain", 200, 100);
        chk("mr_pops", 32'(pops), 32'd16);

`ifdef FIFO_RD_CNT_EN
        // Counter wrap: 65537 pops after reset leave rd_count at 1.
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        pops    = 0;
        exp_idx = rd_cnt;
        wr_cnt  = rd_cnt + 65537;
        wait_drain("cnt_drain", wr_cnt, 66000);
        tick();
        chk("cnt_wrap", 32'(rd_count), 32'h0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
